// File: rtl/sv_alu_param_pkg.sv
// Shared widths, opcode set and arbiter FSM states for the ALU front-end blocks.
// Pure declarations: no logic, no latency, no flow control.
package sv_alu_param_pkg;

    localparam int OP_W   = 4;
    localparam int MOVI_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_MOV = 4'h7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_ABORT
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted req at or after ptr, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; no flow control of its own.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] pos;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters round-robin; one op in flight, watchdog aborts a silent ALU.
// Handshake->ALU strobe 1 cycle, response 1 cycle after result; req_rdy stays low while an op is in flight.
module alu_arbiter
    import sv_alu_param_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_vld,
    output logic [NREQ-1:0]              req_rdy,
    input  logic [NREQ*OP_W-1:0]         req_op,
    input  logic [NREQ*MOVI_W-1:0]       req_movi,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_b,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_mem,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_imm,
    output logic                         alu_rst,
    output logic                         alu_act,
    output logic                         alu_rdy,
    output logic [OP_W-1:0]              alu_op,
    output logic [MOVI_W-1:0]            alu_movi,
    output logic [DATA_WIDTH-1:0]        alu_reg_a,
    output logic [DATA_WIDTH-1:0]        alu_reg_b,
    output logic [DATA_WIDTH-1:0]        alu_mem,
    output logic [DATA_WIDTH-1:0]        alu_imm,
    input  logic [DATA_WIDTH-1:0]        ex_alu,
    input  logic                         ex_alu_vld,
    output logic                         rsp_vld,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic                         rsp_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] gnt;
    logic [IW-1:0]   win_idx;
    logic            win_any;

    logic [OP_W-1:0]       op_arr   [NREQ];
    logic [MOVI_W-1:0]     movi_arr [NREQ];
    logic [DATA_WIDTH-1:0] a_arr    [NREQ];
    logic [DATA_WIDTH-1:0] b_arr    [NREQ];
    logic [DATA_WIDTH-1:0] mem_arr  [NREQ];
    logic [DATA_WIDTH-1:0] imm_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i]   = req_op[i*OP_W +: OP_W];
        assign movi_arr[i] = req_movi[i*MOVI_W +: MOVI_W];
        assign a_arr[i]    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[i]    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        assign mem_arr[i]  = req_mem[i*DATA_WIDTH +: DATA_WIDTH];
        assign imm_arr[i]  = req_imm[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_vld),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    // Grant is only offered while idle and out of reset, so a grant always means a handshake.
    assign req_rdy = (!rst && state == ST_IDLE) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            alu_rst   <= 1'b1;
            alu_act   <= 1'b0;
            alu_rdy   <= 1'b0;
            alu_op    <= '0;
            alu_movi  <= '0;
            alu_reg_a <= '0;
            alu_reg_b <= '0;
            alu_mem   <= '0;
            alu_imm   <= '0;
            rsp_vld   <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            alu_rst  <= 1'b0;
            alu_act  <= 1'b1;
            alu_rdy  <= 1'b0;
            rsp_vld  <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        state     <= ST_ISSUE;
                        alu_rdy   <= 1'b1;
                        alu_op    <= op_arr[win_idx];
                        alu_movi  <= movi_arr[win_idx];
                        alu_reg_a <= a_arr[win_idx];
                        alu_reg_b <= b_arr[win_idx];
                        alu_mem   <= mem_arr[win_idx];
                        alu_imm   <= imm_arr[win_idx];
                        rsp_id    <= win_idx;
                        ptr       <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    // A result on the last watchdog cycle still counts as a success.
                    if (ex_alu_vld) begin
                        state    <= ST_RESP;
                        rsp_vld  <= 1'b1;
                        rsp_data <= ex_alu;
                    end else if (cnt == CNT_LAST) begin
                        state   <= ST_ABORT;
                        rsp_vld <= 1'b1;
                        rsp_err <= 1'b1;
                        alu_rst <= 1'b1;
                        alu_act <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP:  state <= ST_IDLE;
                ST_ABORT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level model.
module tb_alu_arbiter;
    import sv_alu_param_pkg::*;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int TO = 16;
    localparam int IW = 2;
    localparam int OPSW = OP_W + MOVI_W + 4 * DW;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]        req_vld, req_rdy;
    logic [N*OP_W-1:0]   req_op;
    logic [N*MOVI_W-1:0] req_movi;
    logic [N*DW-1:0]     req_a, req_b, req_mem, req_imm;
    logic alu_rst, alu_act, alu_rdy;
    logic [OP_W-1:0]     alu_op;
    logic [MOVI_W-1:0]   alu_movi;
    logic [DW-1:0]       alu_reg_a, alu_reg_b, alu_mem, alu_imm, ex_alu;
    logic                ex_alu_vld;
    logic                rsp_vld, rsp_err;
    logic [IW-1:0]       rsp_id;
    logic [DW-1:0]       rsp_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ALU behaviour controls
    int alu_lat = 1;
    bit rand_alu = 0, rand_stray = 0, stray = 0;

    // event logs observed from the DUT
    int gnt_log[$];
    int hs_log[$];
    int rdy_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
    int rsp_id_l = 0, rsp_data_l = 0;
    bit rsp_err_l = 0, rsp_arst_l = 0, rsp_act_l = 0;

    // transaction-level model
    bit m_after_rst = 1, m_busy = 0, m_pend = 0, m_err = 0;
    int m_age = 0, m_win = 0, m_ptr = 0, m_data = 0;
    logic [OPSW-1:0] m_ops = '0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_movi(req_movi),
        .req_a(req_a), .req_b(req_b), .req_mem(req_mem), .req_imm(req_imm),
        .alu_rst(alu_rst), .alu_act(alu_act), .alu_rdy(alu_rdy),
        .alu_op(alu_op), .alu_movi(alu_movi),
        .alu_reg_a(alu_reg_a), .alu_reg_b(alu_reg_b), .alu_mem(alu_mem), .alu_imm(alu_imm),
        .ex_alu(ex_alu), .ex_alu_vld(ex_alu_vld),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Monitor: compare against the model, log events, then step the model over the coming edge.
    initial begin : monitor
        int g;
        logic [N-1:0] exp_rdy;
        logic exp_act, exp_arst, exp_ardy, exp_rv;
        forever begin
            @(negedge clk);
            cyc++;
            g = first_from(req_vld, m_ptr);
            exp_rdy = '0;
            if (!rst && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
            chk("req_rdy", req_rdy, exp_rdy);

            if (m_after_rst) begin
                exp_act = 0; exp_arst = 1; exp_ardy = 0; exp_rv = 0;
            end else if (m_busy && m_pend) begin
                exp_act = !m_err; exp_arst = m_err; exp_ardy = 0; exp_rv = 1;
            end else begin
                exp_act = 1; exp_arst = 0; exp_ardy = (m_busy && m_age == 1); exp_rv = 0;
            end
            chk("alu_act", alu_act, exp_act);
            chk("alu_rst", alu_rst, exp_arst);
            chk("alu_rdy", alu_rdy, exp_ardy);
            chk("rsp_vld", rsp_vld, exp_rv);
            if (exp_rv) begin
                chk("rsp_err", rsp_err, m_err);
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_id", rsp_id, m_win);
            end
            if (m_after_rst) begin
                chk("rst_rsp_fields", {rsp_id, rsp_data, rsp_err}, 0);
            end
            chk("alu_operands", {alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm}, m_ops);

            if (!rst && (req_vld & req_rdy) != '0) begin
                for (int k = 0; k < N; k++)
                    if (req_vld[k] && req_rdy[k]) gnt_log.push_back(k);
                hs_log.push_back(cyc);
            end
            if (alu_rdy === 1'b1) rdy_cyc = cyc;
            if (rsp_vld === 1'b1) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                rsp_id_l = int'(rsp_id);
                rsp_data_l = int'(rsp_data);
                rsp_err_l = rsp_err;
                rsp_arst_l = alu_rst;
                rsp_act_l = alu_act;
            end

            if (rst) begin
                m_after_rst = 1; m_busy = 0; m_pend = 0; m_ptr = 0; m_win = 0; m_ops = '0;
            end else begin
                m_after_rst = 0;
                if (m_busy) begin
                    if (m_pend) begin
                        m_busy = 0; m_pend = 0;
                    end else if (m_age == 1) begin
                        m_age = 2;
                    end else if (ex_alu_vld) begin
                        m_pend = 1; m_err = 0; m_data = int'(ex_alu);
                    end else if (m_age == TO + 1) begin
                        m_pend = 1; m_err = 1; m_data = 0;
                    end else begin
                        m_age++;
                    end
                end else if (g >= 0) begin
                    m_busy = 1; m_age = 1; m_win = g; m_ptr = (g + 1) % N;
                    m_ops = {req_op[g*OP_W +: OP_W], req_movi[g*MOVI_W +: MOVI_W],
                             req_a[g*DW +: DW], req_b[g*DW +: DW],
                             req_mem[g*DW +: DW], req_imm[g*DW +: DW]};
                end
            end
        end
    end

    // ALU stand-in: answers alu_lat cycles after the strobe (0 = never) with a+b.
    initial begin : alu_model
        int cd;
        int r;
        cd = 0;
        ex_alu_vld = 1'b0;
        ex_alu = '0;
        forever begin
            @(posedge clk); #2;
            ex_alu_vld = 1'b0;
            ex_alu = DW'($urandom);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    ex_alu_vld = 1'b1;
                    ex_alu = alu_reg_a + alu_reg_b;
                end
            end
            if (alu_rdy === 1'b1) begin
                if (rand_alu) begin
                    r = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(1, TO + 1);
                    cd = (r > TO) ? 0 : r;
                end else begin
                    cd = alu_lat;
                end
            end
            if (stray || (rand_stray && $urandom_range(0, 15) == 0)) ex_alu_vld = 1'b1;
        end
    end

    task automatic set_slot(input int i, input logic [OP_W-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_op[i*OP_W +: OP_W] = op;
        req_movi[i*MOVI_W +: MOVI_W] = 2'(i);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_mem[i*DW +: DW] = DW'(8'h10 + i);
        req_imm[i*DW +: DW] = DW'(8'h20 + i);
    endtask

    task automatic hold_until(input int n, input logic [N-1:0] mask);
        int start;
        int t;
        start = hs_log.size();
        t = 0;
        req_vld = mask;
        while (hs_log.size() < start + n && t < 60 * n) begin
            @(posedge clk); #1;
            t++;
        end
        req_vld = '0;
        chk("handshake_count", hs_log.size() - start, n);
    endtask

    task automatic wait_rsp(input int target);
        int t;
        t = 0;
        while (rsp_cnt < target && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rsp_arrived", rsp_cnt >= target, 1);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int n0;
        rst = 1'b1;
        req_vld = '0; req_op = '0; req_movi = '0;
        req_a = '0; req_b = '0; req_mem = '0; req_imm = '0;

        // reset held three cycles
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_alu_rst", alu_rst, 1);
            chk("rst_alu_act", alu_act, 0);
        end
        rst = 1'b0;
        chk("rst_vals", {req_rdy, alu_rdy, rsp_vld, rsp_err, rsp_id, rsp_data}, 0);
        chk("rst_operands", {alu_op, alu_movi, alu_reg_a, alu_reg_b, alu_mem, alu_imm}, 0);
        step(1);
        chk("post_rst_act", {alu_act, alu_rst}, 2'b10);

        // single op: requester 2, 5+3, ALU answers 2 cycles after strobe
        alu_lat = 2;
        set_slot(2, OP_ADD, 8'd5, 8'd3);
        n0 = rsp_cnt;
        hold_until(1, 4'b0100);
        wait_rsp(n0 + 1);
        chk("single_id", rsp_id_l, 2);
        chk("single_data", rsp_data_l, 8);
        chk("single_err", rsp_err_l, 0);
        chk("single_hs_to_rsp", rsp_cyc - hs_log[$], 4);
        chk("single_hs_to_rdy", rdy_cyc - hs_log[$], 1);

        // serve 3 so the pointer wraps, then 0 and 3 pending -> 0 first
        alu_lat = 1;
        for (int i = 0; i < N; i++) set_slot(i, OP_ADD, DW'(i * 3), DW'(i + 1));
        n0 = rsp_cnt;
        hold_until(1, 4'b1000);
        wait_rsp(n0 + 1);
        n0 = rsp_cnt;
        hold_until(2, 4'b1001);
        wait_rsp(n0 + 2);
        chk("wrap_first", gnt_log[gnt_log.size() - 2], 0);
        chk("wrap_second", gnt_log[gnt_log.size() - 1], 3);

        // fairness: all held for eight ops, back-to-back every 4 cycles
        n0 = rsp_cnt;
        hold_until(8, 4'b1111);
        wait_rsp(n0 + 8);
        for (int i = 0; i < 8; i++)
            chk("fair_order", gnt_log[gnt_log.size() - 8 + i], i % 4);
        for (int i = 0; i < 7; i++)
            chk("fair_interval", hs_log[hs_log.size() - 7 + i] - hs_log[hs_log.size() - 8 + i], 4);

        // timeout: ALU never answers
        alu_lat = 0;
        n0 = rsp_cnt;
        hold_until(1, 4'b0010);
        wait_rsp(n0 + 1);
        chk("to_err", rsp_err_l, 1);
        chk("to_data", rsp_data_l, 0);
        chk("to_id", rsp_id_l, 1);
        chk("to_rdy_to_abort", rsp_cyc - rdy_cyc, 17);
        chk("to_alu_rst", rsp_arst_l, 1);
        chk("to_alu_act", rsp_act_l, 0);

        // next op normal
        alu_lat = 3;
        set_slot(1, OP_ADD, 8'd7, 8'd9);
        n0 = rsp_cnt;
        hold_until(1, 4'b0010);
        wait_rsp(n0 + 1);
        chk("after_to_err", rsp_err_l, 0);
        chk("after_to_data", rsp_data_l, 16);

        // result on the last watchdog cycle wins
        alu_lat = TO;
        n0 = rsp_cnt;
        hold_until(1, 4'b0001);
        wait_rsp(n0 + 1);
        chk("edge_err", rsp_err_l, 0);
        chk("edge_rdy_to_rsp", rsp_cyc - rdy_cyc, 17);

        // reset mid-WAIT: no response
        alu_lat = 0;
        n0 = rsp_cnt;
        hold_until(1, 4'b0001);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(25);
        chk("mid_rst_no_rsp", rsp_cnt, n0);

        // after reset pointer is 0: requesters 1 and 2 pending -> 1
        alu_lat = 1;
        n0 = rsp_cnt;
        hold_until(1, 4'b0110);
        wait_rsp(n0 + 1);
        chk("post_rst_grant", gnt_log[$], 1);

        // stray result while idle
        n0 = rsp_cnt;
        stray = 1;
        step(1);
        stray = 0;
        step(5);
        chk("stray_no_rsp", rsp_cnt, n0);

        // randomized traffic
        rand_alu = 1;
        rand_stray = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            req_vld = req_vld ^ N'($urandom & $urandom);
            req_op = (N*OP_W)'($urandom);
            req_movi = (N*MOVI_W)'($urandom);
            req_a = $urandom;
            req_b = $urandom;
            req_mem = $urandom;
            req_imm = $urandom;
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        req_vld = '0;
        rand_alu = 0;
        rand_stray = 0;
        step(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
